traffic_intersection_ctrl: RTL and testbench

Parametrised multi-approach traffic-light controller, successor to the single-approach red/yellow/green controller. Sequences NUM_DIR approaches round-robin through GREEN → YELLOW → ALL_RED, with per-phase programmable durations, demand-based skipping of empty approaches, a hold input, and an optional pedestrian walk phase. Sits at the top of the intersection design and drives the lamp outputs directly.

---
 rtl/tlc_pkg.sv | 18 +
 rtl/tlc_rr_pick.sv | 21 ++
 rtl/traffic_intersection_ctrl.sv | 89 ++++++++
 tb/tb_traffic_intersection_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding, duration defaults and width helper for traffic_intersection_ctrl.
package tlc_pkg;
    typedef enum logic [1:0] {
        ALL_RED  = 2'd0,
        GREEN    = 2'd1,
        YELLOW   = 2'd2,
        PED_WALK = 2'd3
    } tlc_state_e;

    localparam int DEF_GREEN_CYCLES   = 4;
    localparam int DEF_YELLOW_CYCLES  = 2;
    localparam int DEF_ALL_RED_CYCLES = 1;
    localparam int DEF_WALK_CYCLES    = 3;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/tlc_rr_pick.sv
// tlc_rr_pick: round-robin next approach with demand; current approach scanned last, fixed-time fallback.
module tlc_rr_pick import tlc_pkg::*; #(
    parameter int NUM_DIR = 2,
    localparam int DIR_W = clog2_min1(NUM_DIR)
) (
    input  logic [DIR_W-1:0]   active_dir,
    input  logic [NUM_DIR-1:0] car_present,
    output logic [DIR_W-1:0]   next_dir
);
    logic [DIR_W-1:0] idx;

    // Scan from farthest to nearest so the nearest demanding approach wins.
    always_comb begin
        idx = '0;
        next_dir = DIR_W'((int'(active_dir) + 1) % NUM_DIR);
        for (int i = NUM_DIR; i >= 1; i--) begin
            idx = DIR_W'((int'(active_dir) + i) % NUM_DIR);
            if (car_present[idx]) next_dir = idx;
        end
    end
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: round-robin multi-approach lamp sequencer with demand skipping.
// Optional pedestrian walk phase compiled in with TLC_PED_EN.
module traffic_intersection_ctrl import tlc_pkg::*; #(
    parameter int NUM_DIR        = 2,
    parameter int GREEN_CYCLES   = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES  = DEF_YELLOW_CYCLES,
    parameter int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES,
    parameter int WALK_CYCLES    = DEF_WALK_CYCLES,
    localparam int DIR_W = clog2_min1(NUM_DIR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_DIR-1:0] car_present,
    input  logic               ped_req,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic               ped_walk,
    output logic [DIR_W-1:0]   active_dir
);
    localparam int MAX_GY = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    localparam int MAX_RW = (ALL_RED_CYCLES > WALK_CYCLES) ? ALL_RED_CYCLES : WALK_CYCLES;
    localparam int CW = clog2_min1((MAX_GY > MAX_RW) ? MAX_GY : MAX_RW);

    tlc_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, dur_m1;
    logic [DIR_W-1:0] dir_q, dir_d, next_dir;
    logic [NUM_DIR-1:0] onehot;
    logic             done, walk_go;

    tlc_rr_pick #(.NUM_DIR(NUM_DIR)) u_pick (
        .active_dir (dir_q),
        .car_present(car_present),
        .next_dir   (next_dir)
    );

`ifdef TLC_PED_EN
    logic ped_pending_q, ped_pending_d;
    assign walk_go = done && state_q == ALL_RED && ped_pending_q;
    // Entering the walk absorbs a same-edge request; requests during the walk are dropped.
    assign ped_pending_d = walk_go ? 1'b0 : (ped_req && state_q != PED_WALK) ? 1'b1 : ped_pending_q;
    assign ped_walk = state_q == PED_WALK;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ped_pending_q <= 1'b0;
        else ped_pending_q <= ped_pending_d;
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign walk_go = 1'b0;
    assign ped_walk = 1'b0;
`endif

    always_comb begin
        dur_m1 = state_q == GREEN    ? CW'(GREEN_CYCLES - 1)  :
                 state_q == YELLOW   ? CW'(YELLOW_CYCLES - 1) :
                 state_q == PED_WALK ? CW'(WALK_CYCLES - 1)   : CW'(ALL_RED_CYCLES - 1);
        done = enable && cnt_q == dur_m1;
        cnt_d = !enable ? cnt_q : done ? '0 : cnt_q + 1'b1;
        state_d = !done               ? state_q :
                  state_q == GREEN    ? YELLOW  :
                  state_q == YELLOW   ? ALL_RED :
                  state_q == PED_WALK ? ALL_RED :
                  walk_go             ? PED_WALK : GREEN;
        dir_d = (done && state_q == ALL_RED && !walk_go) ? next_dir : dir_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ALL_RED;
            cnt_q   <= '0;
            dir_q   <= DIR_W'(NUM_DIR - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        onehot = NUM_DIR'(1) << dir_q;
        green  = state_q == GREEN  ? onehot : '0;
        yellow = state_q == YELLOW ? onehot : '0;
        red    = ~(green | yellow);
    end

    assign active_dir = dir_q;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: table-driven directed check of the lamp sequence plus reset/freeze sequences.
module tb_traffic_intersection_ctrl;
    localparam int AR = 0, GR = 1, YE = 2, WK = 3;

    logic clk = 1'b0;
    logic reset, enable, ped_req, ped_walk;
    logic [1:0] car_present, red, yellow, green;
    logic active_dir;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic en;
        logic [1:0] car;
        logic ped;
        logic [1:0] r, y, g;
        logic w;
        logic dir;
    } vec_t;
    vec_t vq[$];

    traffic_intersection_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .car_present(car_present),
        .ped_req(ped_req), .red(red), .yellow(yellow), .green(green),
        .ped_walk(ped_walk), .active_dir(active_dir)
    );

    always #5 clk = ~clk;

    function automatic vec_t lamps(input int ph, input logic d);
        vec_t v;
        v.en = 1'b1; v.car = 2'b11; v.ped = 1'b0; v.dir = d;
        v.g = (ph == GR) ? (d ? 2'b10 : 2'b01) : 2'b00;
        v.y = (ph == YE) ? (d ? 2'b10 : 2'b01) : 2'b00;
        v.r = (ph == GR || ph == YE) ? (d ? 2'b01 : 2'b10) : 2'b11;
        v.w = (ph == WK);
        return v;
    endfunction

    task automatic add(input logic en, input logic [1:0] c, input logic p, input int ph, input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v = lamps(ph, d);
            v.en = en; v.car = c; v.ped = (i == 0) ? p : 1'b0;
            vq.push_back(v);
        end
    endtask

    task automatic check(input string nm, input vec_t e);
        n_chk++;
        if (red !== e.r || yellow !== e.y || green !== e.g || ped_walk !== e.w || active_dir !== e.dir) begin
            n_fail++;
            $display("FAIL %s: got r=%b y=%b g=%b w=%b dir=%b, want r=%b y=%b g=%b w=%b dir=%b",
                     nm, red, yellow, green, ped_walk, active_dir, e.r, e.y, e.g, e.w, e.dir);
        end
    endtask

    task automatic tick(input logic en, input logic [1:0] c, input logic p);
        enable = en; car_present = c; ped_req = p;
        @(posedge clk);
        #1 ped_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        #1 check("reset", lamps(AR, 1'b1));
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; car_present = 2'b11; ped_req = 1'b0;
        #12 check("reset_state", lamps(AR, 1'b1));
        @(negedge clk) reset = 1'b0;

        // fixed-time round robin, then demand skipping, then no-demand alternation
        add(1, 2'b11, 0, GR, 0, 4); add(1, 2'b11, 0, YE, 0, 2); add(1, 2'b11, 0, AR, 0, 1);
        add(1, 2'b11, 0, GR, 1, 4); add(1, 2'b11, 0, YE, 1, 2); add(1, 2'b11, 0, AR, 1, 1);
        add(1, 2'b01, 0, GR, 0, 4); add(1, 2'b01, 0, YE, 0, 2); add(1, 2'b01, 0, AR, 0, 1);
        add(1, 2'b01, 0, GR, 0, 4); add(1, 2'b00, 0, YE, 0, 2); add(1, 2'b00, 0, AR, 0, 1);
        add(1, 2'b00, 0, GR, 1, 4); add(1, 2'b00, 0, YE, 1, 2); add(1, 2'b00, 0, AR, 1, 1);
        // pedestrian request during green[0], second request during the walk
        add(1, 2'b00, 0, GR, 0, 1); add(1, 2'b11, 1, GR, 0, 3);
        add(1, 2'b11, 0, YE, 0, 2); add(1, 2'b11, 0, AR, 0, 1);
`ifdef TLC_PED_EN
        add(1, 2'b11, 0, WK, 0, 1); add(1, 2'b11, 1, WK, 0, 1); add(1, 2'b11, 0, WK, 0, 1);
        add(1, 2'b11, 0, AR, 0, 1);
`else
        add(1, 2'b11, 0, GR, 1, 0);
`endif
        add(1, 2'b11, 0, GR, 1, 4); add(1, 2'b11, 0, YE, 1, 2); add(1, 2'b11, 0, AR, 1, 1);
        add(1, 2'b11, 0, GR, 0, 1);

        foreach (vq[i]) begin
            tick(vq[i].en, vq[i].car, vq[i].ped);
            check($sformatf("vec%0d", i), vq[i]);
        end

        // freeze at cnt=2 of green[0] with a pedestrian request during the freeze
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 2'b11, 0);
        check("pre_freeze", lamps(GR, 0));
        for (int i = 0; i < 5; i++) begin
            tick(0, 2'b11, i == 1);
            check($sformatf("freeze%0d", i), lamps(GR, 0));
        end
        tick(1, 2'b11, 0); check("resume_g", lamps(GR, 0));
        tick(1, 2'b11, 0); check("resume_y0", lamps(YE, 0));
        tick(1, 2'b11, 0); check("resume_y1", lamps(YE, 0));
        tick(1, 2'b11, 0); check("resume_ar", lamps(AR, 0));
        tick(1, 2'b11, 0);
`ifdef TLC_PED_EN
        check("frozen_ped_walk", lamps(WK, 0));
`else
        check("frozen_ped_ignored", lamps(GR, 1));
`endif

        // asynchronous reset in the middle of yellow[1]
        do_reset();
        for (int i = 0; i < 12; i++) tick(1, 2'b11, 0);
        check("mid_yellow1", lamps(YE, 1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", lamps(AR, 1));
        @(negedge clk) reset = 1'b0;
        tick(1, 2'b11, 0); check("restart_g0", lamps(GR, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
